tape_buffer_ctrl: RTL and testbench

Byte-buffer controller between the download port, the tape image memory and the `tape` player's buffer read port. It stores the downloaded image into external memory through a req/ack handshake and tracks the image size. It then serves the player's `rd`/`addr` requests by pacing `buff_rd_en` windows, so that `buff_din` is valid on the first cycle `buff_rd_en` is sampled low after a high phase. A one-entry read cache and write-over-read priority keep memory traffic minimal.

---
 rtl/tape_buffer_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_tape_buffer_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_buffer_ctrl.sv
// Tape image byte-buffer controller: stores downloaded bytes to memory through
// a one-entry write slot and serves paced player reads with a one-entry cache.
module tape_buffer_ctrl #(
   parameter int LOW_CYC  = 2,
   parameter int HIGH_CYC = 2
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [24:0] tape_size,
   output logic        wr_overflow,
   output logic        buff_rd_en,
   input  logic        buff_rd,
   input  logic [24:0] buff_addr,
   output logic [7:0]  buff_din,
   output logic        mem_req,
   output logic        mem_we,
   output logic [24:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata
);
   typedef enum logic [1:0] {ST_LOW, ST_HIGH, ST_FETCH, ST_RELEASE} state_t;

   localparam logic [3:0] LOW_LAST  = 4'(LOW_CYC - 1);
   localparam logic [3:0] HIGH_LAST = 4'(HIGH_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [24:0] rd_addr_q, rd_addr_d;
   logic [7:0]  buff_din_q, buff_din_d;
   logic        cache_vld_q, cache_vld_d;
   logic [24:0] cache_tag_q, cache_tag_d;
   logic [7:0]  cache_data_q, cache_data_d;
   logic        slot_full_q, slot_full_d;
   logic [24:0] slot_addr_q, slot_addr_d;
   logic [7:0]  slot_data_q, slot_data_d;
   logic [24:0] tape_size_q, tape_size_d;
   logic        wr_overflow_q, wr_overflow_d;
   logic        dl_q, dl_d;
   logic        rd_stale_q, rd_stale_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [24:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_wdata_q, mem_wdata_d;

   logic        dl_rise, cache_hit, rd_done, wr_done, rd_issue;
   logic [24:0] wr_end, size_base;

   assign dl_d      = ioctl_download;
   assign dl_rise   = ioctl_download & ~dl_q;
   assign cache_hit = cache_vld_q && (cache_tag_q == rd_addr_q);
   assign rd_done   = mem_req_q && !mem_we_q && mem_ack;
   assign wr_done   = mem_req_q && mem_we_q && mem_ack;
   assign wr_end    = ioctl_addr + 25'd1;

   // Player-side FSM: pace read windows, serve hits from cache, issue misses.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_addr_d    = rd_addr_q;
      buff_din_d   = buff_din_q;
      cache_vld_d  = cache_vld_q;
      cache_tag_d  = cache_tag_q;
      cache_data_d = cache_data_q;
      rd_issue     = 1'b0;
      if (dl_rise) cache_vld_d = 1'b0;
      case (state_q)
         ST_LOW: begin
            if (cnt_q >= LOW_LAST && !ioctl_download) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q < LOW_LAST) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_HIGH: begin
            if (dl_rise) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (buff_rd) begin
               state_d   = ST_FETCH;
               rd_addr_d = buff_addr;
            end else if (cnt_q >= HIGH_LAST) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_FETCH: begin
            // A download start abandons the read; any read still on the bus
            // is marked stale so its data never reaches buff_din or the cache.
            if (dl_rise) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cache_hit) begin
               buff_din_d = cache_data_q;
               state_d    = ST_RELEASE;
            end else if (rd_done && !rd_stale_q) begin
               buff_din_d   = mem_rdata;
               cache_vld_d  = 1'b1;
               cache_tag_d  = rd_addr_q;
               cache_data_d = mem_rdata;
               state_d      = ST_RELEASE;
            end else if (!mem_req_q && !slot_full_q) begin
               rd_issue = 1'b1;
            end
         end
         default: begin
            // RELEASE is the first low cycle of the next low phase.
            state_d = ST_LOW;
            cnt_d   = 4'd1;
         end
      endcase
   end

   // Download side: write slot, image size, overflow flag and memory arbiter.
   always_comb begin
      slot_full_d   = slot_full_q;
      slot_addr_d   = slot_addr_q;
      slot_data_d   = slot_data_q;
      wr_overflow_d = wr_overflow_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      rd_stale_d    = rd_stale_q;
      size_base     = dl_rise ? 25'd0 : tape_size_q;
      tape_size_d   = size_base;
      if (dl_rise) wr_overflow_d = 1'b0;
      if (wr_done) slot_full_d = 1'b0;
      if (ioctl_wr) begin
         if (slot_full_q) begin
            wr_overflow_d = 1'b1;
         end else begin
            slot_full_d = 1'b1;
            slot_addr_d = ioctl_addr;
            slot_data_d = ioctl_dout;
            if (wr_end > size_base) tape_size_d = wr_end;
         end
      end
      if (mem_req_q && mem_ack) rd_stale_d = 1'b0;
      if (dl_rise && mem_req_q && !mem_we_q && !mem_ack) rd_stale_d = 1'b1;
      // One request in flight; a full write slot beats a pending read miss.
      if (mem_req_q) begin
         if (mem_ack) mem_req_d = 1'b0;
      end else if (slot_full_q) begin
         mem_req_d   = 1'b1;
         mem_we_d    = 1'b1;
         mem_addr_d  = slot_addr_q;
         mem_wdata_d = slot_data_q;
      end else if (rd_issue) begin
         mem_req_d  = 1'b1;
         mem_we_d   = 1'b0;
         mem_addr_d = rd_addr_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q       <= ST_LOW;
         cnt_q         <= '0;
         rd_addr_q     <= '0;
         buff_din_q    <= '0;
         cache_vld_q   <= 1'b0;
         cache_tag_q   <= '0;
         cache_data_q  <= '0;
         slot_full_q   <= 1'b0;
         slot_addr_q   <= '0;
         slot_data_q   <= '0;
         tape_size_q   <= '0;
         wr_overflow_q <= 1'b0;
         dl_q          <= 1'b0;
         rd_stale_q    <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rd_addr_q     <= rd_addr_d;
         buff_din_q    <= buff_din_d;
         cache_vld_q   <= cache_vld_d;
         cache_tag_q   <= cache_tag_d;
         cache_data_q  <= cache_data_d;
         slot_full_q   <= slot_full_d;
         slot_addr_q   <= slot_addr_d;
         slot_data_q   <= slot_data_d;
         tape_size_q   <= tape_size_d;
         wr_overflow_q <= wr_overflow_d;
         dl_q          <= dl_d;
         rd_stale_q    <= rd_stale_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign buff_rd_en  = (state_q == ST_HIGH) || (state_q == ST_FETCH);
   assign buff_din    = buff_din_q;
   assign tape_size   = tape_size_q;
   assign wr_overflow = wr_overflow_q;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_tape_buffer_ctrl.sv
// Bench for tape_buffer_ctrl: behavioural memory responder plus an
// expectation model of image contents, size, cache and read latency.
module tb_tape_buffer_ctrl;
   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0, ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [24:0] tape_size;
   logic        wr_overflow, buff_rd_en;
   logic        buff_rd = 1'b0;
   logic [24:0] buff_addr = '0;
   logic [7:0]  buff_din;
   logic        mem_req, mem_we;
   logic [24:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   always #5 clk_sys = ~clk_sys;

   tape_buffer_ctrl #(.LOW_CYC(2), .HIGH_CYC(2)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .tape_size(tape_size), .wr_overflow(wr_overflow), .buff_rd_en(buff_rd_en),
      .buff_rd(buff_rd), .buff_addr(buff_addr), .buff_din(buff_din),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   typedef struct packed { logic [24:0] a; logic [7:0] d; } wr_t;

   int checks = 0, failures = 0;
   int cyc = 0;
   int en_hi = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // memory responder (acts at posedge+1, main flow at posedge+2)
   logic [7:0] mem [bit [24:0]];
   wr_t wr_log[$];
   wr_t rsp_w;
   int  ack_lat = 3, age = 0, n_rd = 0, last_ack_cyc = -100;
   bit  stray = 1'b0;
   initial begin
      mem_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk_sys); #1;
         mem_ack = stray;
         if (mem_req) begin
            if (age == ack_lat) begin
               mem_ack = 1'b1;
               last_ack_cyc = cyc;
               if (mem_we) begin
                  mem[mem_addr] = mem_wdata;
                  rsp_w.a = mem_addr; rsp_w.d = mem_wdata;
                  wr_log.push_back(rsp_w);
               end else begin
                  mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
                  n_rd++;
               end
            end
            age++;
         end else begin
            age = 0;
         end
      end
   end

   // expectation model
   logic [7:0]  ref_mem [bit [24:0]];
   wr_t         exp_wr[$];
   logic [24:0] exp_size = '0;
   bit          cache_ok = 1'b0;
   logic [24:0] cache_addr = '0;
   logic [7:0]  exp_din = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys); #2;
      en_hi += int'(buff_rd_en);
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
   endtask

   // strobe a write the bench expects to be accepted, and record its effect
   task automatic acc_write(input logic [24:0] a, input logic [7:0] d);
      wr_t w;
      logic [24:0] e;
      strobe(a, d);
      w.a = a; w.d = d;
      exp_wr.push_back(w);
      ref_mem[a] = d;
      e = a + 25'd1;
      if (e > exp_size) exp_size = e;
   endtask

   task automatic cmp_log(input string tag);
      int bad = 0;
      chk({tag, "_wrcount"}, wr_log.size(), exp_wr.size());
      for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
         if (wr_log[i] !== exp_wr[i]) bad++;
      chk({tag, "_wrorder"}, bad, 0);
      wr_log.delete();
      exp_wr.delete();
   endtask

   task automatic do_read(input logic [24:0] a, input int lat, input string tag, input bit inj);
      logic [7:0] exp_d;
      bit hit;
      int n0, t_rd, k;
      ack_lat = lat;
      hit = cache_ok && (cache_addr == a);
      exp_d = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
      k = 0;
      while (!buff_rd_en && k < 40) begin tick(); k++; end
      chk({tag, "_window"}, buff_rd_en, 1);
      n0 = n_rd;
      buff_addr = a; buff_rd = 1'b1; t_rd = cyc;
      tick();
      buff_rd = 1'b0;
      if (inj) begin
         k = 0;
         while (cyc < t_rd + 2 + lat && k < 20) begin tick(); k++; end
         acc_write(25'd300, 8'($urandom));
      end
      k = 0;
      while (buff_rd_en && k < 60) begin tick(); k++; end
      chk({tag, "_fall"}, buff_rd_en, 0);
      chk({tag, "_latency"}, cyc - (hit ? t_rd : last_ack_cyc), hit ? 2 : 1);
      chk({tag, "_data"}, buff_din, exp_d);
      chk({tag, "_memrd"}, n_rd - n0, hit ? 0 : 1);
      cache_ok = 1'b1; cache_addr = a; exp_din = exp_d;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [24:0] a;
      logic [7:0]  d;
      int n0, k;

      // reset state and idle window pattern
      repeat (3) @(posedge clk_sys);
      #2;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_rd_en", buff_rd_en, 0);
      chk("rst_tape_size", tape_size, 0);
      chk("rst_misc", {wr_overflow, mem_we, buff_din, mem_addr, mem_wdata}, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("idle_en_%0d", i), buff_rd_en, ((i % 4) >= 2) ? 1 : 0);
         tick();
      end

      // download bytes 0..99, byte 99 = A5
      ioctl_download = 1'b1;
      tick();
      en_hi = 0;
      ack_lat = 3;
      for (int i = 0; i < 100; i++) begin
         d = (i == 99) ? 8'hA5 : 8'($urandom);
         acc_write(25'(i), d);
         repeat (7) tick();
      end
      cmp_log("dl100");
      chk("dl100_size", tape_size, exp_size);
      chk("dl100_ovf", wr_overflow, 0);
      chk("dl100_rd_en", en_hi, 0);

      // overflow: second strobe one cycle later is dropped
      ack_lat = 5;
      acc_write(25'd200, 8'($urandom));
      strobe(25'd201, 8'($urandom));
      repeat (12) tick();
      cmp_log("ovf");
      chk("ovf_flag", wr_overflow, 1);
      chk("ovf_size", tape_size, exp_size);

      // stray ack while the slot is full but no request is out
      ack_lat = 3;
      stray = 1'b1;
      acc_write(25'd210, 8'($urandom));
      stray = 1'b0;
      repeat (10) tick();
      cmp_log("stray");
      chk("stray_size", tape_size, exp_size);
      ioctl_download = 1'b0;
      tick();

      // read miss then cache hit on addr 99
      do_read(25'd99, 4, "miss99", 1'b0);
      do_read(25'd99, 4, "hit99", 1'b0);

      // randomized reads
      for (int i = 0; i < 8; i++) begin
         a = ($urandom_range(3, 0) == 0) ? cache_addr : 25'($urandom_range(99, 0));
         do_read(a, int'($urandom_range(6, 0)), $sformatf("rnd%0d", i), 1'b0);
      end

      // write strobe in the same cycle as a read ack
      a = (cache_addr == 25'd7) ? 25'd8 : 25'd7;
      do_read(a, 3, "simul", 1'b1);
      repeat (8) tick();
      cmp_log("simul");
      chk("simul_size", tape_size, exp_size);

      // download rises with a read miss on the bus
      a = (cache_addr == 25'd50) ? 25'd51 : 25'd50;
      ack_lat = 6;
      k = 0;
      while (!buff_rd_en && k < 40) begin tick(); k++; end
      buff_addr = a; buff_rd = 1'b1;
      tick();
      buff_rd = 1'b0;
      k = 0;
      while (!mem_req && k < 20) begin tick(); k++; end
      n0 = n_rd;
      ioctl_download = 1'b1;
      tick();
      en_hi = 0;
      exp_size = '0;
      cache_ok = 1'b0;
      chk("dlrd_size_clr", tape_size, 0);
      chk("dlrd_ovf_clr", wr_overflow, 0);
      repeat (12) tick();
      chk("dlrd_bus_done", n_rd - n0, 1);
      chk("dlrd_req_idle", mem_req, 0);
      chk("dlrd_din_kept", buff_din, exp_din);
      // size wraps to 0 at the top address
      ack_lat = 2;
      acc_write(25'h1FFFFFF, 8'($urandom));
      repeat (8) tick();
      chk("wrap_size", tape_size, exp_size);
      cmp_log("wrap");
      chk("dlrd_rd_en", en_hi, 0);
      ioctl_download = 1'b0;
      do_read(a, 3, "postdl", 1'b0);

      // async reset in the middle of a write request
      ack_lat = 6;
      strobe(25'd400, 8'h11);
      k = 0;
      while (!mem_req && k < 20) begin tick(); k++; end
      #1 reset = 1'b1;
      #1;
      chk("arst_mem_req", mem_req, 0);
      chk("arst_out", {buff_rd_en, buff_din, tape_size}, 0);
      tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("arst_idle_req", mem_req, 0);
      chk("arst_nowrite", wr_log.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
